// File: rtl/tile_scroller_if.sv
// Tile memory bus between the scroller (master) and the screen RAM (slave).
// The RAM returns read data one cycle after the address is presented.
interface tile_scroller_if;
    logic [10:0] mem_addr;
    logic [2:0]  mem_rd_data;
    logic        mem_we;
    logic [2:0]  mem_wr_data;

    modport master (
        output mem_addr,
        output mem_we,
        output mem_wr_data,
        input  mem_rd_data
    );

    modport slave (
        input  mem_addr,
        input  mem_we,
        input  mem_wr_data,
        output mem_rd_data
    );
endinterface

// File: rtl/tile_scroller.sv
// Tile screen scroller: every FRAMES_PER_STEP vsync falling edges it shifts
// the 40x30 tile map down one row, keeps ship tiles in place, flags
// asteroid-on-ship collisions and fills row 0 with LFSR-driven asteroids.
module tile_scroller #(
    parameter int          COLS            = 40,
    parameter int          ROWS            = 30,
    parameter int          FRAMES_PER_STEP = 4,
    parameter logic [2:0]  BLANK_CHAR      = 3'd0,
    parameter logic [2:0]  ASTEROID_CHAR   = 3'd1,
    parameter logic [2:0]  SHIP_CHAR       = 3'd2,
    parameter logic [15:0] SEED            = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   vsync,
    input  logic                   enable,
    input  logic [7:0]             density,
    tile_scroller_if.master        bus,
    output logic                   busy,
    output logic                   step_done,
    output logic                   hit,
    input  logic                   hit_clear
);

    localparam int                 CNT_W    = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);
    localparam logic [10:0]        COLS_A   = 11'(COLS);
    localparam logic [10:0]        LAST_A   = 11'(ROWS * COLS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_SRC,
        RD_DST,
        WR,
        FILL
    } state_t;

    state_t            state_reg;
    logic [10:0]       addr_reg;
    logic [CNT_W-1:0]  frame_cnt_reg;
    logic              vsync_q_reg;
    logic [15:0]       lfsr_reg;
    logic [2:0]        src_reg;
    logic              hit_reg;
    logic              busy_reg;
    logic              step_done_reg;

    logic              vsync_fall;
    logic              step_due;
    logic              hit_set;
    logic              fill_asteroid;
    logic [15:0]       lfsr_next;

    // Frame boundary detection and per-cycle decisions shared by the FSM.
    assign vsync_fall    = vsync_q_reg & ~vsync;
    assign step_due      = vsync_fall & enable & (frame_cnt_reg == CNT_LAST);
    assign lfsr_next     = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    assign fill_asteroid = (lfsr_reg[7:0] < density);
    // An asteroid falling onto a ship tile is a collision; the ship tile itself is never rewritten.
    assign hit_set       = (state_reg == WR) && (bus.mem_rd_data == SHIP_CHAR) && (src_reg == ASTEROID_CHAR);

    assign busy      = busy_reg;
    assign step_done = step_done_reg;
    assign hit       = hit_reg;

    // Sequencer: frame counting, copy loop (read src, read dst, write), then row-0 fill.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            frame_cnt_reg <= '0;
            vsync_q_reg   <= 1'b1;
            lfsr_reg      <= SEED;
            src_reg       <= BLANK_CHAR;
            hit_reg       <= 1'b0;
            busy_reg      <= 1'b0;
            step_done_reg <= 1'b0;
        end else begin
            vsync_q_reg   <= vsync;
            step_done_reg <= 1'b0;
            // Set has priority over clear so a collision is never lost.
            hit_reg       <= hit_set | (hit_reg & ~hit_clear);

            // The counter keeps running during a step; a start that falls due mid-step is dropped.
            if (vsync_fall && enable) begin
                if (frame_cnt_reg == CNT_LAST) begin
                    frame_cnt_reg <= '0;
                end else begin
                    frame_cnt_reg <= frame_cnt_reg + 1'b1;
                end
            end

            case (state_reg)
                IDLE: begin
                    if (step_due) begin
                        state_reg <= RD_SRC;
                        addr_reg  <= LAST_A;
                        busy_reg  <= 1'b1;
                    end
                end
                RD_SRC: begin
                    state_reg <= RD_DST;
                end
                RD_DST: begin
                    src_reg   <= bus.mem_rd_data;
                    state_reg <= WR;
                end
                WR: begin
                    if (addr_reg == COLS_A) begin
                        addr_reg  <= COLS_A - 11'd1;
                        state_reg <= FILL;
                    end else begin
                        addr_reg  <= addr_reg - 11'd1;
                        state_reg <= RD_SRC;
                    end
                end
                FILL: begin
                    lfsr_reg <= lfsr_next;
                    if (addr_reg == 11'd0) begin
                        state_reg     <= IDLE;
                        busy_reg      <= 1'b0;
                        step_done_reg <= 1'b1;
                    end else begin
                        addr_reg <= addr_reg - 11'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Memory port decode; the write decision in WR depends on the dst tile arriving this cycle.
    always_comb begin
        bus.mem_addr    = '0;
        bus.mem_we      = 1'b0;
        bus.mem_wr_data = BLANK_CHAR;
        case (state_reg)
            RD_SRC: begin
                bus.mem_addr = (addr_reg >= COLS_A) ? (addr_reg - COLS_A) : 11'd0;
            end
            RD_DST: begin
                bus.mem_addr = addr_reg;
            end
            WR: begin
                bus.mem_addr = addr_reg;
                if (bus.mem_rd_data == SHIP_CHAR) begin
                    bus.mem_we = 1'b0;
                end else if (src_reg == SHIP_CHAR) begin
                    bus.mem_we      = 1'b1;
                    bus.mem_wr_data = BLANK_CHAR;
                end else begin
                    bus.mem_we      = 1'b1;
                    bus.mem_wr_data = src_reg;
                end
            end
            FILL: begin
                bus.mem_addr    = addr_reg;
                bus.mem_we      = 1'b1;
                bus.mem_wr_data = fill_asteroid ? ASTEROID_CHAR : BLANK_CHAR;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/tile_scroller.md
Name: tile_scroller

Overview:
- Upstream feeder of the 40x30 tile screen memory that the VGA display driver reads through screenAddr.
- Once every FRAMES_PER_STEP frames, on a vsync falling edge, it scrolls the screen down one tile row.
- Rows 0..28 are copied into rows 1..29, and a fresh pseudo-random asteroid row is written into row 0.
- It preserves ship tiles and flags asteroid-ship collisions. All work completes inside vertical blanking.

Parameters:
- COLS, 40, tiles per row (640>>4).
- ROWS, 30, tile rows (480>>4).
- FRAMES_PER_STEP, 4, vsync falling edges per scroll step (>=1).
- BLANK_CHAR, 3'd0, empty tile code.
- ASTEROID_CHAR, 3'd1, asteroid tile code.
- SHIP_CHAR, 3'd2, ship tile code.
- SEED, 16'hACE1, LFSR reset value (nonzero).

Ports:
- clk  in  1  system/pixel clock.
- reset  in  1  asynchronous, active-high reset.
- vsync  in  1  active-low vsync from the VGA timer, synchronous to clk.
- enable  in  1  scrolling permitted; frame counter holds when 0.
- density  in  8  asteroid probability per top-row tile, density/256.
- mem_addr  out  11  tile memory address, row*COLS+col.
- mem_rd_data  in  3  tile memory read data; 1-cycle registered read latency.
- mem_we  out  1  tile memory write enable.
- mem_wr_data  out  3  tile memory write data.
- busy  out  1  scroll step in progress.
- step_done  out  1  one-cycle pulse at end of step.
- hit  out  1  sticky collision flag.
- hit_clear  in  1  clears hit.

Behaviour:
- Reset values: state IDLE, addr reg 0, frame count 0, vsync_q 1, lfsr SEED, hit 0. Outputs: busy 0, step_done 0, mem_we 0, mem_addr 0, mem_wr_data 0.
- Reset mid-step aborts immediately. Any write already issued stands, with no cleanup.
- Edge detect: vsync_q registers vsync. An edge exists in cycle T when vsync_q=1 and vsync=0.
- Frame counter increments on each edge while enable=1. At count FRAMES_PER_STEP-1, an edge sets count to 0 and starts a step.
- If an edge arrives while busy=1, the counter still advances. A start that falls due while busy is dropped, never queued.
- Start timing: the state enters RD_SRC at T+1, with addr=ROWS*COLS-1 (1199) and busy=1.
- RD_SRC: mem_addr = addr-COLS. mem_we=0.
- RD_DST: mem_addr = addr. Latch mem_rd_data as src.
- WR: mem_addr = addr. mem_rd_data is dst. The write rule, in priority order:
  - If dst==SHIP_CHAR, then mem_we=0. Additionally, if src==ASTEROID_CHAR, set hit.
  - Otherwise, if src==SHIP_CHAR, write BLANK_CHAR (the ship never moves).
  - Otherwise, write src.
- After WR: if addr==COLS, set addr=COLS-1 and go to FILL. Otherwise decrement addr and go to RD_SRC.
- FILL: mem_addr=addr, mem_we=1.
  - mem_wr_data = ASTEROID_CHAR if lfsr[7:0] < density, else BLANK_CHAR.
  - The LFSR advances every FILL cycle and no other time.
  - If addr==0, go to IDLE. Otherwise decrement addr.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Shifts left, with the XOR of bits 15,13,12,10 entering bit 0.
- Step length: 3*(1200-40)+40 = 3520 cycles with busy=1.
- On the cycle after the final FILL: busy=0, step_done=1 for exactly one cycle, state IDLE.
- This fits in vblank: 45 lines*800 = 36000 cycles.
- hit: set by the collision rule, cleared by hit_clear. If set and clear occur in the same cycle, set wins.
- In IDLE, mem_we=0 and mem_addr=0.
- Width rule: addr is 11 bits, and addr-COLS is computed only when addr>=COLS.

Test Plan:
- Reset with vsync=1, then 3 falling edges -> busy stays 0.
  - 4th edge at cycle T -> busy=1 at T+1.
  - step_done pulses at T+3521. mem_we never asserts outside busy.
- Model memory preloaded blank except addr 203=ASTEROID, density=0, one step:
  - addr 243=ASTEROID, addr 203=BLANK.
  - All of 0..39 are BLANK. Exactly 1200 write-or-skip slots occur.
- Ship at addr 1190, asteroid at addr 1150, step:
  - hit=1, addr 1190 still SHIP, no write to 1190.
  - hit_clear pulse -> hit=0. hit_clear coincident with a new collision -> hit=1.
- Ship at addr 1130 (row 28), step -> addr 1170=BLANK, addr 1130 unchanged.
- density=255, SEED default, step:
  - Row 0 matches a golden LFSR model, tile by tile from addr 39 down to 0.
  - The LFSR state after the step equals SEED advanced 40 times.
- Assert reset 100 cycles into a step -> busy=0, mem_we=0 immediately, lfsr=SEED.
  - The next step starts only after a full FRAMES_PER_STEP edges.
- enable=0 during edges -> the counter holds. Extra edges while busy are counted, and no second step is queued.
